// File: rtl/joint_pwm_ramp.sv
// joint_pwm_ramp: conditions the host's signed duty command for the PWM/DIR joint stage.
// Saturates to the PWM period, applies a deadband, and slews the output by at most
// RAMP_STEP per ramp tick.
// Optional build macro JOINT_PWM_RAMP_WATCHDOG_EN adds a command watchdog. If host
// updates stop arriving, the watchdog faults the joint and ramps it down to zero.
module joint_pwm_ramp #(
  parameter int unsigned PWM_PERIOD      = 100000,
  parameter int unsigned RAMP_DIV        = 1000,
  parameter int unsigned RAMP_STEP       = 100,
  parameter int unsigned DEADBAND        = 0,
  parameter int unsigned WATCHDOG_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jointEnable,
  input  logic        cmdValid,
  input  logic [31:0] jointDutyCmd,
  output logic [31:0] jointFreqCmd,
  output logic        atTarget,
  output logic        faultWatchdog
);

  localparam int unsigned W  = 32;
  localparam int unsigned WE = 33;

  localparam logic signed [WE-1:0] PERIOD_P = WE'(PWM_PERIOD);
  localparam logic signed [WE-1:0] STEP_P   = WE'(RAMP_STEP);
  localparam logic signed [WE-1:0] DB_P     = WE'(DEADBAND);
  localparam logic [W-1:0]         TICK_END = W'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t                state_q;
  logic signed [W-1:0]   target_q;
  logic signed [W-1:0]   out_q;
  logic [W-1:0]          tick_q;

  logic                  tick_c;
  logic                  expire_c;
  logic signed [WE-1:0]  cmd_ext_c;
  logic signed [WE-1:0]  clamped_c;
  logic signed [W-1:0]   sat_c;
  logic signed [WE-1:0]  out_ext_c;
  logic signed [WE-1:0]  tgt_ext_c;
  logic signed [WE-1:0]  up_c;
  logic signed [WE-1:0]  dn_c;
  logic signed [W-1:0]   ramp_c;

  assign tick_c = (tick_q == TICK_END);

  // Saturate the raw command to +/-PWM_PERIOD, then squash the deadband to zero
  always_comb begin
    cmd_ext_c = WE'($signed(jointDutyCmd));
    clamped_c = cmd_ext_c;
    sat_c     = '0;
    if (cmd_ext_c > PERIOD_P) begin
      clamped_c = PERIOD_P;
    end else if (cmd_ext_c < -PERIOD_P) begin
      clamped_c = -PERIOD_P;
    end
    if ((clamped_c > DB_P) || (clamped_c < -DB_P)) begin
      sat_c = W'(clamped_c);
    end
  end

  // One bounded step toward the target; 33-bit math keeps the step from wrapping
  always_comb begin
    out_ext_c = WE'(out_q);
    tgt_ext_c = WE'(target_q);
    up_c      = out_ext_c + STEP_P;
    dn_c      = out_ext_c - STEP_P;
    ramp_c    = out_q;
    if (out_ext_c < tgt_ext_c) begin
      ramp_c = (up_c > tgt_ext_c) ? target_q : W'(up_c);
    end else if (out_ext_c > tgt_ext_c) begin
      ramp_c = (dn_c < tgt_ext_c) ? target_q : W'(dn_c);
    end
  end

`ifdef JOINT_PWM_RAMP_WATCHDOG_EN
  logic [W-1:0] wd_q;

  // Count RUN cycles since the last host command; cleared outside RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else if ((state_q == RUN) && jointEnable && !cmdValid) begin
      wd_q <= wd_q + W'(1);
    end else begin
      wd_q <= '0;
    end
  end

  assign expire_c      = (wd_q == W'(WATCHDOG_CYCLES - 1));
  assign faultWatchdog = (state_q == FAULT);
`else
  assign expire_c      = 1'b0;
  assign faultWatchdog = 1'b0;
`endif

  // Free-running ramp prescaler, active in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
    end else if (tick_c) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + W'(1);
    end
  end

  // Joint state machine with target capture and output slewing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      out_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          out_q    <= '0;
          target_q <= '0;
          if (jointEnable) begin
            state_q <= RUN;
            if (cmdValid) begin
              target_q <= sat_c;
            end
          end
        end
        RUN: begin
          if (!jointEnable) begin
            state_q  <= IDLE;
            out_q    <= '0;
            target_q <= '0;
          end else begin
            if (tick_c) begin
              out_q <= ramp_c;
            end
            if (cmdValid) begin
              target_q <= sat_c;
            end else if (expire_c) begin
              state_q  <= FAULT;
              target_q <= '0;
            end
          end
        end
        FAULT: begin
          if (!jointEnable) begin
            state_q  <= IDLE;
            out_q    <= '0;
            target_q <= '0;
          end else if (tick_c) begin
            out_q <= ramp_c;
          end
        end
        default: begin
          state_q  <= IDLE;
          out_q    <= '0;
          target_q <= '0;
        end
      endcase
    end
  end

  assign jointFreqCmd = out_q;
  assign atTarget     = (out_q == target_q);

endmodule

// File: tb/tb_joint_pwm_ramp.sv
// Testbench for joint_pwm_ramp: directed scenarios plus randomized traffic, each cycle
// checked against a behavioural model of the command conditioner.
module tb_joint_pwm_ramp;

  localparam int PER  = 100;
  localparam int DIV  = 4;
  localparam int STEP = 10;
  localparam int DB   = 5;
  localparam int WDC  = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jointEnable = 1'b0;
  logic        cmdValid = 1'b0;
  logic [31:0] jointDutyCmd = '0;
  logic [31:0] jointFreqCmd;
  logic        atTarget;
  logic        faultWatchdog;

  joint_pwm_ramp #(
    .PWM_PERIOD(PER), .RAMP_DIV(DIV), .RAMP_STEP(STEP),
    .DEADBAND(DB), .WATCHDOG_CYCLES(WDC)
  ) dut (
    .clk(clk), .rst(rst), .jointEnable(jointEnable), .cmdValid(cmdValid),
    .jointDutyCmd(jointDutyCmd), .jointFreqCmd(jointFreqCmd),
    .atTarget(atTarget), .faultWatchdog(faultWatchdog)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: mode 0=idle 1=running 2=faulted
  longint m_out = 0, m_tgt = 0;
  int     m_mode = 0, m_phase = 0, m_quiet = 0;
  bit     m_fault = 0;

  int     cur_cmd = 0;
  int     since_cv = 0;
  bit     keepalive = 1;
  int     cyc_no = 0;

  function automatic longint sat(input int c);
    longint v;
    v = c;
    if (v > PER) v = PER;
    if (v < -PER) v = -PER;
    if (v <= DB && v >= -DB) v = 0;
    return v;
  endfunction

  function automatic longint toward(input longint cur, input longint goal);
    if (cur < goal) return (cur + STEP > goal) ? goal : cur + STEP;
    if (cur > goal) return (cur - STEP < goal) ? goal : cur - STEP;
    return cur;
  endfunction

  // advance one clock, update the model from the applied inputs, then compare
  task automatic cyc();
    bit tick;
    bit wd_on;
    tick = (m_phase == DIV - 1);
`ifdef JOINT_PWM_RAMP_WATCHDOG_EN
    wd_on = 1'b1;
`else
    wd_on = 1'b0;
`endif
    @(posedge clk);
    if (rst) begin
      m_out = 0; m_tgt = 0; m_mode = 0; m_phase = 0; m_quiet = 0; m_fault = 0;
    end else begin
      m_phase = tick ? 0 : m_phase + 1;
      if (!jointEnable) begin
        m_out = 0; m_tgt = 0; m_mode = 0; m_quiet = 0; m_fault = 0;
      end else if (m_mode == 0) begin
        m_mode = 1; m_quiet = 0;
        if (cmdValid) m_tgt = sat($signed(jointDutyCmd));
      end else if (m_mode == 1) begin
        if (tick) m_out = toward(m_out, m_tgt);
        if (cmdValid) begin
          m_tgt = sat($signed(jointDutyCmd)); m_quiet = 0;
        end else if (wd_on && m_quiet == WDC - 1) begin
          m_mode = 2; m_tgt = 0; m_fault = 1; m_quiet = 0;
        end else begin
          m_quiet++;
        end
      end else begin
        if (tick) m_out = toward(m_out, 0);
      end
    end
    since_cv = cmdValid ? 0 : since_cv + 1;
    cyc_no++;
    #1;
    n_vec++;
    if (jointFreqCmd !== 32'(m_out)) begin
      n_err++;
      $display("FAIL model_out cyc %0d: got %0d exp %0d", cyc_no, $signed(jointFreqCmd), m_out);
    end
    n_vec++;
    if (atTarget !== (m_out == m_tgt)) begin
      n_err++;
      $display("FAIL model_attarget cyc %0d: got %b exp %b", cyc_no, atTarget, m_out == m_tgt);
    end
    n_vec++;
    if (faultWatchdog !== m_fault) begin
      n_err++;
      $display("FAIL model_fault cyc %0d: got %b exp %b", cyc_no, faultWatchdog, m_fault);
    end
  endtask

  task automatic send(input int cmd);
    cur_cmd = cmd;
    jointDutyCmd = cmd;
    cmdValid = 1'b1;
    cyc();
    cmdValid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (keepalive && since_cv >= 20) begin
        jointDutyCmd = cur_cmd;
        cmdValid = 1'b1;
      end
      cyc();
      cmdValid = 1'b0;
    end
  endtask

  // run up to n cycles and record each distinct output value with its cycle number
  task automatic collect(input int n, output int vals[$], output int when[$]);
    logic [31:0] prev;
    vals = {};
    when = {};
    prev = jointFreqCmd;
    for (int i = 0; i < n; i++) begin
      run(1);
      if (jointFreqCmd !== prev) begin
        vals.push_back($signed(jointFreqCmd));
        when.push_back(cyc_no);
        prev = jointFreqCmd;
      end
    end
  endtask

  task automatic check_seq(input string nm, input int got[$], input int gw[$], input int exp_v[$]);
    n_vec++;
    if (got.size() != exp_v.size()) begin
      n_err++;
      $display("FAIL %s_len: got %0d exp %0d", nm, got.size(), exp_v.size());
    end else begin
      for (int i = 0; i < exp_v.size(); i++) begin
        n_vec++;
        if (got[i] != exp_v[i]) begin
          n_err++;
          $display("FAIL %s[%0d]: got %0d exp %0d", nm, i, got[i], exp_v[i]);
        end
        if (i > 0) begin
          n_vec++;
          if (gw[i] - gw[i-1] != DIV) begin
            n_err++;
            $display("FAIL %s_spacing[%0d]: got %0d exp %0d", nm, i, gw[i] - gw[i-1], DIV);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    jointEnable = 1'b0;
    repeat (3) cyc();
    n_vec++;
    if (jointFreqCmd !== 32'd0 || atTarget !== 1'b1 || faultWatchdog !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got out=%0d at=%b flt=%b exp 0/1/0",
               $signed(jointFreqCmd), atTarget, faultWatchdog);
    end
    rst = 1'b0;
    send(40);
    run(10);
    n_vec++;
    if (jointFreqCmd !== 32'd0) begin
      n_err++;
      $display("FAIL disabled_cmd: got %0d exp 0", $signed(jointFreqCmd));
    end
  endtask

  task automatic test_ramp_up();
    int v[$], w[$];
    jointEnable = 1'b1;
    send(35);
    collect(40, v, w);
    check_seq("ramp_up", v, w, '{10, 20, 30, 35});
    n_vec++;
    if (atTarget !== 1'b1) begin
      n_err++;
      $display("FAIL ramp_up_attarget: got %b exp 1", atTarget);
    end
  endtask

  task automatic test_reverse();
    int v[$], w[$];
    send(-25);
    collect(40, v, w);
    check_seq("reverse", v, w, '{25, 15, 5, -5, -15, -25});
  endtask

  task automatic test_clamp();
    send(500);
    n_vec++;
    if (atTarget !== 1'b0) begin
      n_err++;
      $display("FAIL clamp_pos_attarget: got %b exp 0", atTarget);
    end
    run(80);
    n_vec++;
    if ($signed(jointFreqCmd) != 100 || atTarget !== 1'b1) begin
      n_err++;
      $display("FAIL clamp_pos: got %0d at=%b exp 100 at=1", $signed(jointFreqCmd), atTarget);
    end
    send(32'sh8000_0000);
    run(120);
    n_vec++;
    if ($signed(jointFreqCmd) != -100 || atTarget !== 1'b1) begin
      n_err++;
      $display("FAIL clamp_neg: got %0d at=%b exp -100 at=1", $signed(jointFreqCmd), atTarget);
    end
    send(4);
    run(60);
    n_vec++;
    if ($signed(jointFreqCmd) != 0 || atTarget !== 1'b1) begin
      n_err++;
      $display("FAIL deadband_pos: got %0d at=%b exp 0 at=1", $signed(jointFreqCmd), atTarget);
    end
    send(-5);
    run(2);
    n_vec++;
    if ($signed(jointFreqCmd) != 0 || atTarget !== 1'b1) begin
      n_err++;
      $display("FAIL deadband_neg: got %0d at=%b exp 0 at=1", $signed(jointFreqCmd), atTarget);
    end
  endtask

  task automatic test_disable();
    send(60);
    run(40);
    n_vec++;
    if ($signed(jointFreqCmd) != 60) begin
      n_err++;
      $display("FAIL disable_setup: got %0d exp 60", $signed(jointFreqCmd));
    end
    jointEnable = 1'b0;
    cyc();
    n_vec++;
    if (jointFreqCmd !== 32'd0) begin
      n_err++;
      $display("FAIL disable_stop: got %0d exp 0", $signed(jointFreqCmd));
    end
    cur_cmd = 0;
    jointEnable = 1'b1;
    run(9);
    n_vec++;
    if (jointFreqCmd !== 32'd0 || atTarget !== 1'b1) begin
      n_err++;
      $display("FAIL reenable: got %0d at=%b exp 0 at=1", $signed(jointFreqCmd), atTarget);
    end
  endtask

`ifdef JOINT_PWM_RAMP_WATCHDOG_EN
  task automatic test_watchdog();
    int v[$], w[$];
    send(60);
    run(40);
    keepalive = 0;
    send(60);
    run(WDC - 1);
    n_vec++;
    if (faultWatchdog !== 1'b0) begin
      n_err++;
      $display("FAIL wd_early: got %b exp 0", faultWatchdog);
    end
    run(1);
    n_vec++;
    if (faultWatchdog !== 1'b1) begin
      n_err++;
      $display("FAIL wd_expire: got %b exp 1", faultWatchdog);
    end
    collect(60, v, w);
    check_seq("wd_rampdown", v, w, '{50, 40, 30, 20, 10, 0});
    send(80);
    run(12);
    n_vec++;
    if (jointFreqCmd !== 32'd0 || faultWatchdog !== 1'b1) begin
      n_err++;
      $display("FAIL wd_ignore: got %0d flt=%b exp 0 flt=1", $signed(jointFreqCmd), faultWatchdog);
    end
    jointEnable = 1'b0;
    cyc();
    n_vec++;
    if (faultWatchdog !== 1'b0) begin
      n_err++;
      $display("FAIL wd_clear: got %b exp 0", faultWatchdog);
    end
    jointEnable = 1'b1;
    send(30);
    run(WDC - 1);
    send(30);
    run(3);
    n_vec++;
    if (faultWatchdog !== 1'b0) begin
      n_err++;
      $display("FAIL wd_race: got %b exp 0", faultWatchdog);
    end
    keepalive = 1;
  endtask
`endif

  task automatic test_random();
    int pick;
    keepalive = 0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) jointEnable = ~jointEnable;
      cmdValid = ($urandom_range(0, 9) == 0);
      pick = $urandom_range(0, 5);
      case (pick)
        0: jointDutyCmd = 32'h8000_0000;
        1: jointDutyCmd = 32'h7fff_ffff;
        2: jointDutyCmd = 32'($signed($urandom_range(0, 12)) - 6);
        default: jointDutyCmd = 32'($signed($urandom_range(0, 300)) - 150);
      endcase
      cyc();
    end
    rst = 1'b0;
    cmdValid = 1'b0;
    keepalive = 1;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reverse();
    test_clamp();
    test_disable();
`ifdef JOINT_PWM_RAMP_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
